alu_sequencer: RTL and testbench

Control unit that drives the 8-bit ALU from the other side of its interface. It fetches 10-bit instructions over a req/valid handshake and holds a 4x8 register file. It presents opcode, addrs and operands to the ALU, then consumes the ALU result, carry/borrow and branch/toggle strobes. From these it writes back, updates flags and advances or redirects the PC.

---
 rtl/alu_sequencer.sv | 99 +++++++++
 tb/tb_alu_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/exec control unit that drives an 8-bit ALU from a 4x8 register file
module alu_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            ld_en,
    input  logic [1:0]      ld_sel,
    input  logic [7:0]      ld_data,
    output logic            fetch_req,
    output logic [PC_W-1:0] pc,
    input  logic            fetch_valid,
    input  logic [9:0]      instr,
    output logic [1:0]      alu_opcode,
    output logic [3:0]      alu_addrs,
    output logic [7:0]      alu_din0,
    output logic [7:0]      alu_din1,
    input  logic [7:0]      alu_dout,
    input  logic            alu_carry,
    input  logic            alu_borrow,
    input  logic            alu_bcf,
    input  logic            alu_bbf,
    input  logic            alu_buc,
    input  logic            alu_toggle,
    output logic            carry_flag,
    output logic            borrow_flag,
    output logic            toggle_out,
    output logic            instr_done,
    input  logic [1:0]      dbg_sel,
    output logic [7:0]      dbg_data
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC} stateType;

    stateType   state;
    stateType   nextState;
    logic [9:0] ir;
    logic [7:0] regFile [4];
    logic [1:0] rd;
    logic [1:0] rs;
    logic       branchCtl;
    logic       taken;

    assign rd         = ir[3:2];
    assign rs         = ir[1:0];
    assign alu_opcode = ir[9:8];
    assign alu_addrs  = ir[7:4];
    assign alu_din0   = regFile[rd];
    assign alu_din1   = regFile[rs];
    assign dbg_data   = regFile[dbg_sel];
    assign branchCtl  = (ir[9:8] == 2'b11) && (alu_bcf || alu_bbf || alu_buc);
    assign taken      = branchCtl && (alu_buc || (alu_bcf && carry_flag) || (alu_bbf && borrow_flag));

    // next-state and handshake outputs; a valid fetch wins over run dropping
    always_comb begin
        nextState  = state;
        fetch_req  = 1'b0;
        instr_done = 1'b0;
        case (state)
            IDLE:    nextState = run ? FETCH : IDLE;
            FETCH: begin
                fetch_req = 1'b1;
                nextState = fetch_valid ? EXEC : (run ? FETCH : IDLE);
            end
            EXEC: begin
                instr_done = 1'b1;
                nextState  = run ? FETCH : IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // state register, preload, instruction latch and EXEC writeback; branch flags are the pre-EXEC values
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            ir          <= '0;
            regFile     <= '{default: '0};
            carry_flag  <= 1'b0;
            borrow_flag <= 1'b0;
            toggle_out  <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                IDLE:    if (ld_en) regFile[ld_sel] <= ld_data;
                FETCH:   if (fetch_valid) ir <= instr;
                EXEC: begin
                    if (!branchCtl) regFile[rd] <= alu_dout;
                    if (ir[9:8] == 2'b00) carry_flag <= alu_carry;
                    if (ir[9:8] == 2'b01) borrow_flag <= alu_borrow;
                    if (alu_toggle) toggle_out <= ~toggle_out;
                    pc <= taken ? PC_W'(regFile[rs]) : pc + PC_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed table, hand sequences and random instructions against an arithmetic reference model
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       ld_en = 1'b0;
    logic [1:0] ld_sel = '0;
    logic [7:0] ld_data = '0;
    logic       fetch_req;
    logic [7:0] pc;
    logic       fetch_valid = 1'b0;
    logic [9:0] instr = '0;
    logic [1:0] alu_opcode;
    logic [3:0] alu_addrs;
    logic [7:0] alu_din0, alu_din1, alu_dout;
    logic       alu_carry, alu_borrow;
    logic       alu_bcf = 1'b0, alu_bbf = 1'b0, alu_buc = 1'b0, alu_toggle = 1'b0;
    logic       carry_flag, borrow_flag, toggle_out, instr_done;
    logic [1:0] dbg_sel = '0;
    logic [7:0] dbg_data;
    logic [8:0] aluSum;

    alu_sequencer #(.PC_W(8)) dut (
        .clk(clk), .rst(rst), .run(run), .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
        .fetch_req(fetch_req), .pc(pc), .fetch_valid(fetch_valid), .instr(instr),
        .alu_opcode(alu_opcode), .alu_addrs(alu_addrs), .alu_din0(alu_din0), .alu_din1(alu_din1),
        .alu_dout(alu_dout), .alu_carry(alu_carry), .alu_borrow(alu_borrow),
        .alu_bcf(alu_bcf), .alu_bbf(alu_bbf), .alu_buc(alu_buc), .alu_toggle(alu_toggle),
        .carry_flag(carry_flag), .borrow_flag(borrow_flag), .toggle_out(toggle_out),
        .instr_done(instr_done), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // ALU stub: add/sub/xor/mov on the presented operands
    assign aluSum     = {1'b0, alu_din0} + {1'b0, alu_din1};
    assign alu_carry  = aluSum[8];
    assign alu_borrow = alu_din0 < alu_din1;
    assign alu_dout   = alu_opcode == 2'd0 ? aluSum[7:0] :
                        alu_opcode == 2'd1 ? alu_din0 - alu_din1 :
                        alu_opcode == 2'd2 ? alu_din0 ^ alu_din1 : alu_din1;

    int checks = 0;
    int errors = 0;
    int mRegs [4];
    int mPc, mCarry, mBorrow, mTog;
    logic [9:0] mIr;

    typedef struct {
        logic [31:0] pre;
        logic [9:0]  ins;
        logic [3:0]  str;
        logic [1:0]  idx;
        logic [7:0]  val;
        logic        c;
        logic        b;
        logic [7:0]  pcE;
    } vecType;
    vecType vecs [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        for (int k = 0; k < 4; k++) mRegs[k] = 0;
        mPc = 0; mCarry = 0; mBorrow = 0; mTog = 0; mIr = '0;
    endtask

    task automatic modelExec(input logic [9:0] i, input logic [3:0] s);
        int op, rd, rs, a, b;
        bit jump;
        op = int'(i[9:8]); rd = int'(i[3:2]); rs = int'(i[1:0]);
        a = mRegs[rd]; b = mRegs[rs]; jump = 0;
        if (op == 0) begin
            mRegs[rd] = (a + b) % 256;
            mCarry = (a + b > 255) ? 1 : 0;
        end else if (op == 1) begin
            mRegs[rd] = (a - b + 256) % 256;
            mBorrow = (a < b) ? 1 : 0;
        end else if (op == 2) begin
            mRegs[rd] = a ^ b;
        end else if (s[3:1] != 3'b000) begin
            jump = s[1] || (s[3] && mCarry == 1) || (s[2] && mBorrow == 1);
        end else begin
            mRegs[rd] = b;
        end
        mPc = jump ? b : (mPc + 1) % 256;
        if (s[0]) mTog = 1 - mTog;
        mIr = i;
    endtask

    task automatic checkState(input string tag);
        for (int k = 0; k < 4; k++) begin
            dbg_sel = 2'(k);
            #1;
            chk($sformatf("%s_r%0d", tag, k), 32'(dbg_data), mRegs[k]);
        end
        chk({tag, "_pc"}, 32'(pc), mPc);
        chk({tag, "_carry"}, 32'(carry_flag), mCarry);
        chk({tag, "_borrow"}, 32'(borrow_flag), mBorrow);
        chk({tag, "_toggle"}, 32'(toggle_out), mTog);
    endtask

    task automatic preload(input logic [31:0] pre);
        ld_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ld_sel = 2'(k);
            ld_data = pre[8*k +: 8];
            tick();
            mRegs[k] = int'(pre[8*k +: 8]);
        end
        ld_en = 1'b0;
    endtask

    // expects to be called one step after an edge with the DUT in FETCH
    task automatic runOne(input logic [9:0] i, input logic [3:0] s, input int waitCyc, input bit dropRun, input string tag);
        chk({tag, "_req"}, 32'(fetch_req), 1);
        for (int w = 0; w < waitCyc; w++) begin
            fetch_valid = 1'b0;
            tick();
            chk({tag, "_waitreq"}, 32'(fetch_req), 1);
            chk({tag, "_waitpc"}, 32'(pc), mPc);
        end
        fetch_valid = 1'b1;
        instr = i;
        {alu_bcf, alu_bbf, alu_buc, alu_toggle} = s;
        if (dropRun) run = 1'b0;
        tick();
        fetch_valid = 1'b0;
        instr = 10'($urandom);
        chk({tag, "_done"}, 32'(instr_done), 1);
        chk({tag, "_opc"}, 32'(alu_opcode), 32'(i[9:8]));
        modelExec(i, s);
        tick();
        {alu_bcf, alu_bbf, alu_buc, alu_toggle} = 4'b0;
        chk({tag, "_done0"}, 32'(instr_done), 0);
        chk({tag, "_reqafter"}, 32'(fetch_req), dropRun ? 0 : 1);
        checkState(tag);
    endtask

    initial begin
        logic [3:0] s;
        vecs[0]  = '{32'h00030500, 10'h006, 4'b0000, 2'd1, 8'h08, 1'b0, 1'b0, 8'h01};
        vecs[1]  = '{32'h0020F000, 10'h006, 4'b0000, 2'd1, 8'h10, 1'b1, 1'b0, 8'h02};
        vecs[2]  = '{32'h00030500, 10'h109, 4'b0000, 2'd2, 8'hFE, 1'b1, 1'b1, 8'h03};
        vecs[3]  = '{32'h40000077, 10'h303, 4'b1000, 2'd0, 8'h77, 1'b1, 1'b1, 8'h40};
        vecs[4]  = '{32'h00000101, 10'h001, 4'b0000, 2'd0, 8'h02, 1'b0, 1'b1, 8'h41};
        vecs[5]  = '{32'h40000077, 10'h303, 4'b1000, 2'd0, 8'h77, 1'b0, 1'b1, 8'h42};
        vecs[6]  = '{32'h90000077, 10'h303, 4'b0010, 2'd0, 8'h77, 1'b0, 1'b1, 8'h90};
        vecs[7]  = '{32'h00205500, 10'h306, 4'b0100, 2'd1, 8'h55, 1'b0, 1'b1, 8'h20};
        vecs[8]  = '{32'hAB000000, 10'h30B, 4'b0000, 2'd2, 8'hAB, 1'b0, 1'b1, 8'h21};
        vecs[9]  = '{32'h0000FF0F, 10'h201, 4'b0000, 2'd0, 8'hF0, 1'b0, 1'b1, 8'h22};
        vecs[10] = '{32'h81000000, 10'h00F, 4'b0000, 2'd3, 8'h02, 1'b1, 1'b1, 8'h23};
        vecs[11] = '{32'h00000010, 10'h100, 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0, 8'h24};
        vecs[12] = '{32'hFF000000, 10'h303, 4'b0011, 2'd0, 8'h00, 1'b1, 1'b0, 8'hFF};
        vecs[13] = '{32'h00000F3C, 10'h2A1, 4'b0000, 2'd0, 8'h33, 1'b1, 1'b0, 8'h00};
        vecs[14] = '{32'h00205500, 10'h306, 4'b0100, 2'd1, 8'h55, 1'b1, 1'b0, 8'h01};
        modelReset();
        tick();
        tick();
        rst = 1'b0;
        checkState("reset");
        chk("reset_req", 32'(fetch_req), 0);
        chk("reset_done", 32'(instr_done), 0);
        for (int v = 0; v < 15; v++) begin
            preload(vecs[v].pre);
            run = 1'b1;
            tick();
            runOne(vecs[v].ins, vecs[v].str, 0, 1'b1, $sformatf("vec%0d", v));
            dbg_sel = vecs[v].idx;
            #1;
            chk($sformatf("vec%0d_reg", v), 32'(dbg_data), 32'(vecs[v].val));
            chk($sformatf("vec%0d_c", v), 32'(carry_flag), 32'(vecs[v].c));
            chk($sformatf("vec%0d_b", v), 32'(borrow_flag), 32'(vecs[v].b));
            chk($sformatf("vec%0d_pc", v), 32'(pc), 32'(vecs[v].pcE));
        end
        fetch_valid = 1'b1;
        instr = 10'h0F0;
        tick();
        fetch_valid = 1'b0;
        chk("stray_req", 32'(fetch_req), 0);
        chk("stray_done", 32'(instr_done), 0);
        chk("stray_opc", 32'(alu_opcode), 32'(mIr[9:8]));
        chk("stray_addrs", 32'(alu_addrs), 32'(mIr[7:4]));
        checkState("stray");
        run = 1'b1;
        tick();
        chk("abort_req1", 32'(fetch_req), 1);
        run = 1'b0;
        tick();
        chk("abort_req0", 32'(fetch_req), 0);
        tick();
        chk("abort_done", 32'(instr_done), 0);
        run = 1'b1;
        tick();
        runOne(10'h2A1, 4'b0001, 3, 1'b0, "tog1");
        chk("tog1_val", 32'(toggle_out), 0);
        runOne(10'h006, 4'b0001, 0, 1'b0, "tog2");
        chk("tog2_val", 32'(toggle_out), 1);
        for (int n = 0; n < 300; n++) begin
            s[3] = $urandom_range(0, 3) == 0;
            s[2] = $urandom_range(0, 3) == 0;
            s[1] = $urandom_range(0, 3) == 0;
            s[0] = $urandom_range(0, 1) == 1;
            runOne(10'($urandom), s, $urandom_range(0, 2), n % 25 == 24, $sformatf("rnd%0d", n));
            if (n % 25 == 24) begin
                preload($urandom);
                run = 1'b1;
                tick();
            end
        end
        fetch_valid = 1'b1;
        instr = 10'h006;
        alu_toggle = 1'b1;
        tick();
        fetch_valid = 1'b0;
        chk("midexec_done", 32'(instr_done), 1);
        rst = 1'b1;
        run = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        alu_toggle = 1'b0;
        modelReset();
        checkState("midrst");
        chk("midrst_req", 32'(fetch_req), 0);
        chk("midrst_done", 32'(instr_done), 0);
        chk("midrst_opc", 32'(alu_opcode), 0);
        tick();
        chk("midrst_idle", 32'(fetch_req), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
